vec_store_serializer: RTL and testbench



---
 rtl/vec_store_serializer.sv | 120 ++++++++++++
 tb/tb_vec_store_serializer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vec_store_serializer.sv
// Vector store serializer: accepts one vecSize-lane vector and writes its
// mask-enabled lanes, lowest lane first, one per cycle into a scalar memory.
module vec_store_serializer #(
  parameter int regSize = 16,
  parameter int vecSize = 4,
  parameter int ADDR_W  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [vecSize-1:0][regSize-1:0] vect_in,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [vecSize-1:0]              lane_mask,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [regSize-1:0]              mem_wdata,
  input  logic                            mem_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            dbg_state
);

  localparam int IDX_W = (vecSize > 1) ? $clog2(vecSize) : 1;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [vecSize-1:0][regSize-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0]               base_q, base_d;
  logic [vecSize-1:0]              mask_q, mask_d;
  logic [IDX_W-1:0]                lane_q, lane_d;
  logic                            done_q, done_d;
  logic [IDX_W:0]                  first_hit, next_hit;

  // Lowest set bit of m at or above position start; MSB of result = found.
  function automatic logic [IDX_W:0] find_from(input logic [vecSize-1:0] m,
                                               input int start);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = vecSize - 1; i >= 0; i--) begin
      if (m[i] && (i >= start)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  assign first_hit = find_from(lane_mask, 0);
  assign next_hit  = find_from(mask_q, int'(lane_q) + 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      base_q  <= '0;
      mask_q  <= '0;
      lane_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      lane_q  <= lane_d;
      done_q  <= done_d;
    end
  end

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready;
  // a memory write completes on a rising edge where mem_we && mem_ready.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    base_d  = base_q;
    mask_d  = mask_q;
    lane_d  = lane_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d  = vect_in;
          base_d = base_addr;
          mask_d = lane_mask;
          if (first_hit[IDX_W]) begin
            state_d = WRITE;
            lane_d  = first_hit[IDX_W-1:0];
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          if (next_hit[IDX_W]) begin
            lane_d = next_hit[IDX_W-1:0];
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registers, so they hold steady under backpressure.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == WRITE);
    mem_we    = (state_q == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == WRITE) begin
      mem_addr  = base_q + ADDR_W'(lane_q);
      mem_wdata = vec_q[lane_q];
    end
    done      = done_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_vec_store_serializer.sv
// Directed bench for vec_store_serializer: table of vectors with hand-computed
// write sequences, plus backpressure and mid-transaction reset sequences.
module tb_vec_store_serializer;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0][15:0]     vect_in;
  logic [15:0]          base_addr;
  logic [3:0]           lane_mask;
  logic                 mem_we;
  logic [15:0]          mem_addr;
  logic [15:0]          mem_wdata;
  logic                 mem_ready;
  logic                 busy;
  logic                 done;
  logic                 dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]       mask;
    logic [15:0]      base;
    logic [3:0][15:0] data;
    int               n;
    logic [3:0][15:0] ea;
    logic [3:0][15:0] ed;
  } vec_t;

  vec_t tbl[7];

  vec_store_serializer #(.regSize(16), .vecSize(4), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .vect_in(vect_in), .base_addr(base_addr), .lane_mask(lane_mask),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] mask, input logic [15:0] base,
                              input logic [63:0] data, input int n,
                              input logic [63:0] ea, input logic [63:0] ed);
    vec_t v;
    v.mask = mask; v.base = base; v.data = data;
    v.n = n; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic scramble_inputs();
    vect_in   = {$urandom, $urandom};
    base_addr = 16'($urandom);
    lane_mask = 4'($urandom_range(0, 15));
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid  = 1'b1;
    vect_in   = v.data;
    base_addr = v.base;
    lane_mask = v.mask;
  endtask

  task automatic check_write(input string tag);
    logic [31:0] e;
    chk({tag, " mem_we"}, 32'(mem_we), 32'd1);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " dbg_state"}, 32'(dbg_state), 32'd1);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s write: unexpected write addr=0x%0h data=0x%0h", tag, mem_addr, mem_wdata);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " addr,data"}, {mem_addr, mem_wdata}, e);
    end
  endtask

  task automatic check_done(input string tag);
    chk({tag, " done pulse"}, 32'(done), 32'd1);
    chk({tag, " in_ready at done"}, 32'(in_ready), 32'd1);
    chk({tag, " mem_we at done"}, 32'(mem_we), 32'd0);
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
  endtask

  // Full transaction with mem_ready held high; called at a negedge.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    drive_vec(v);
    for (int i = 0; i < v.n; i++) exp_q.push_back({v.ea[i], v.ed[i]});
    @(posedge clk);
    #1 in_valid = 1'b0;
    scramble_inputs();
    for (int j = 0; j < v.n; j++) begin
      @(negedge clk);
      check_write(tag);
    end
    @(negedge clk);
    check_done(tag);
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    tbl[0] = mk(4'hf, 16'h0100, 64'h4444_3333_2222_1111, 4,
                64'h0103_0102_0101_0100, 64'h4444_3333_2222_1111);
    tbl[1] = mk(4'ha, 16'h0200, 64'h4444_3333_2222_1111, 2,
                64'h0000_0000_0203_0201, 64'h0000_0000_4444_2222);
    tbl[2] = mk(4'h0, 16'h0300, 64'h4444_3333_2222_1111, 0, 64'h0, 64'h0);
    tbl[3] = mk(4'hf, 16'hfffe, 64'h4444_3333_2222_1111, 4,
                64'h0001_0000_ffff_fffe, 64'h4444_3333_2222_1111);
    tbl[4] = mk(4'h4, 16'h1234, 64'hd3d3_c2c2_b1b1_a0a0, 1, 64'h1236, 64'hc2c2);
    tbl[5] = mk(4'h9, 16'h0050, 64'h4444_3333_2222_1111, 2,
                64'h0000_0000_0053_0050, 64'h0000_0000_4444_1111);
    tbl[6] = mk(4'h1, 16'h0010, 64'h0000_0000_0000_beef, 1, 64'h0010, 64'hbeef);

    reset = 1'b1; in_valid = 1'b0; mem_ready = 1'b1;
    vect_in = '0; base_addr = '0; lane_mask = '0;
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset addr,data", {mem_addr, mem_wdata}, 32'd0);
    chk("reset dbg_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 6; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Backpressure: lane 0 held for cycles N+1..N+4, done in N+8.
    @(negedge clk);
    drive_vec(tbl[0]);
    for (int i = 0; i < 4; i++) exp_q.push_back({tbl[0].ea[i], tbl[0].ed[i]});
    @(posedge clk);
    #1 in_valid = 1'b0; mem_ready = 1'b0;
    scramble_inputs();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("bp held addr,data", {mem_addr, mem_wdata}, 32'h0100_1111);
      chk("bp held mem_we", 32'(mem_we), 32'd1);
      chk("bp held in_ready", 32'(in_ready), 32'd0);
      if (c == 4) mem_ready = 1'b1;
    end
    void'(exp_q.pop_front());
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      check_write("bp");
    end
    @(negedge clk);
    check_done("bp");
    @(negedge clk);
    chk("bp done one cycle", 32'(done), 32'd0);

    // Reset during the second lane write, then a fresh single-lane vector.
    @(negedge clk);
    drive_vec(tbl[0]);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rst lane0 addr,data", {mem_addr, mem_wdata}, 32'h0100_1111);
    @(negedge clk);
    chk("rst lane1 addr,data", {mem_addr, mem_wdata}, 32'h0101_2222);
    reset = 1'b1;
    #1;
    chk("rst async mem_we", 32'(mem_we), 32'd0);
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async in_ready", 32'(in_ready), 32'd1);
    chk("rst async addr,data", {mem_addr, mem_wdata}, 32'd0);
    chk("rst async done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst no done", 32'(done), 32'd0);
      chk("rst no write", 32'(mem_we), 32'd0);
    end
    run_vec(tbl[6], "post_rst");

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
